// File: rtl/axi_line_bridge_if.sv
// Cache-side miss interface plus AXI4 read/write channels between the data cache and memory.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface axi_line_bridge_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;

  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic         bready;

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
           arready, rdata, rlast, rvalid, awready, wready, bvalid,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
           araddr, arlen, arvalid, rready,
           awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready
  );

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
           arready, rdata, rlast, rvalid, awready, wready, bvalid,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
           araddr, arlen, arvalid, rready,
           awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/axi_line_bridge.sv
// Converts cache line/word misses into single AXI4 read and write bursts, one outstanding per
// direction, with independent read and write FSMs and a read-after-write line hazard check.
module axi_line_bridge (
  input  logic              clk,
  input  logic              resetn,
  axi_line_bridge_if.slave  bus
);

  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} wr_state_e;

  rd_state_e    rd_state_q, rd_state_d;
  logic [31:0]  araddr_q, araddr_d;
  logic [7:0]   arlen_q, arlen_d;

  wr_state_e    wr_state_q, wr_state_d;
  logic [31:0]  awaddr_q, awaddr_d;
  logic [7:0]   awlen_q, awlen_d;
  logic [127:0] wbuf_q, wbuf_d;
  logic [3:0]   wstrb_q, wstrb_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         aw_done_q, aw_done_d;
  logic         w_done_q, w_done_d;

  logic         hazard;
  logic         beat_last;

  // A read must not overtake a write to the same 16-byte line, whether buffered or arriving now.
  always_comb begin
    hazard = ((wr_state_q != W_IDLE) && (bus.rd_addr[31:4] == awaddr_q[31:4])) ||
             (bus.wr_req && (bus.rd_addr[31:4] == bus.wr_addr[31:4]));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      araddr_q   <= '0;
      arlen_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
    end
  end

  always_comb begin
    rd_state_d    = rd_state_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    bus.rd_rdy    = 1'b0;
    bus.arvalid   = 1'b0;
    bus.rready    = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        bus.rd_rdy = !hazard;
        if (bus.rd_req && !hazard) begin
          araddr_d   = bus.rd_addr;
          arlen_d    = (bus.rd_type == TYPE_LINE) ? 8'd3 : 8'd0;
          rd_state_d = R_AR;
        end
      end
      R_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        bus.rready    = 1'b1;
        bus.ret_valid = bus.rvalid;
        bus.ret_last  = bus.rvalid && bus.rlast;
        if (bus.rvalid && bus.rlast) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign bus.araddr   = araddr_q;
  assign bus.arlen    = arlen_q;
  assign bus.ret_data = bus.rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state_q <= W_IDLE;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      wbuf_q     <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      wbuf_q     <= wbuf_d;
      wstrb_q    <= wstrb_d;
      cnt_q      <= cnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign beat_last = ({6'd0, cnt_q} == awlen_q);

  // AW and W retire independently; the response phase waits for both, in either order.
  always_comb begin
    wr_state_d  = wr_state_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    wbuf_d      = wbuf_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bus.wr_rdy  = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.wlast   = 1'b0;
    bus.bready  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        bus.wr_rdy = 1'b1;
        if (bus.wr_req) begin
          awaddr_d   = bus.wr_addr;
          awlen_d    = (bus.wr_type == TYPE_LINE) ? 8'd3 : 8'd0;
          wbuf_d     = bus.wr_data;
          wstrb_d    = (bus.wr_type == TYPE_LINE) ? 4'hf : bus.wr_wstrb;
          cnt_d      = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_BUSY;
        end
      end
      W_BUSY: begin
        bus.awvalid = !aw_done_q;
        bus.wvalid  = !w_done_q;
        bus.wlast   = !w_done_q && beat_last;
        if (!aw_done_q && bus.awready) aw_done_d = 1'b1;
        if (!w_done_q && bus.wready) begin
          if (beat_last) w_done_d = 1'b1;
          else           cnt_d    = cnt_q + 2'd1;
        end
        if ((aw_done_q || bus.awready) && (w_done_q || (bus.wready && beat_last)))
          wr_state_d = W_RESP;
      end
      W_RESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign bus.awaddr = awaddr_q;
  assign bus.awlen  = awlen_q;
  assign bus.wdata  = wbuf_q[{cnt_q, 5'd0} +: 32];
  assign bus.wstrb  = wstrb_q;

endmodule

// File: doc/axi_line_bridge.md
Name: axi_line_bridge

Overview:
Downstream neighbour of the data cache. Converts the cache's line/word miss interface (rd_req/ret_*, wr_req/wr_rdy) into AXI4 read and write bursts toward the memory interconnect. One outstanding read and one outstanding write at a time, with an independent FSM per direction and a read-after-write line hazard check.

Parameters:
none. AXI id, lock, cache, prot, size (3'b010) and burst (INCR) are constants driven in the top wrapper.

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
rd_req  in  1  cache read request, held until rd_rdy
rd_type  in  3  3'b100 = 16-byte line, 3'b010 = word
rd_addr  in  32  read address (line-aligned for line reads)
rd_rdy  out  1  read request accepted this cycle
ret_valid  out  1  read data beat valid
ret_last  out  1  last read beat
ret_data  out  32  read beat data
wr_req  in  1  one-cycle write request; only issued while wr_rdy=1
wr_type  in  3  3'b100 = line, 3'b010 = word
wr_addr  in  32  write address
wr_wstrb  in  4  byte strobes, word writes only
wr_data  in  128  line data; word writes use bits [31:0]
wr_rdy  out  1  write buffer empty
araddr  out  32  AR address
arlen  out  8  3 for line, 0 for word
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  R data
rlast  in  1  R last
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  AW address
awlen  out  8  3 for line, 0 for word
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  W data
wstrb  out  4  W strobes
wlast  out  1  W last
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Reset: all valid/ready/last outputs 0; rd_rdy=1, wr_rdy=1; address, len and data registers 0. Assertion mid-transaction abandons the AXI transfer immediately, with no drain.
- Read FSM R_IDLE->R_AR->R_DATA. rd_rdy = R_IDLE && !hazard. On rd_req&&rd_rdy: latch araddr and arlen; arvalid=1 from the next cycle, held with a stable address until arready. Then R_DATA: rready=1; ret_valid=rvalid, ret_last=rvalid&&rlast, ret_data=rdata (combinational pass-through). rvalid&&rlast -> R_IDLE, so rd_rdy can return the next cycle.
- hazard = (write buffer busy && rd_addr[31:4]==buffered awaddr[31:4]) || (wr_req && rd_addr[31:4]==wr_addr[31:4]).
- Write FSM W_IDLE->W_BUSY->W_RESP. wr_rdy = W_IDLE. On wr_req: capture address, len, the 128-bit data, and strobes (4'hf for line, wr_wstrb for word). Next cycle, awvalid=1 and wvalid=1 together; AW and W complete independently.
- Beat counter 0..awlen: wdata = buf[cnt*32 +: 32]; wlast = (cnt==awlen); the counter advances only on wvalid&&wready. wdata and wstrb are held stable during stalls.
- W_BUSY->W_RESP once AW has handshaken and the wlast beat has handshaken, in either order. In W_RESP bready=1; bvalid -> W_IDLE.
- bresp and rresp are ignored. Read and write FSMs run concurrently. AXI valid is never deasserted before its ready.

Test Plan:
- Line read 0x1c000040, rd_type 100 -> araddr 0x1c000040, arlen 3. R beats 0x11,0x22,0x33,0x44 -> 4 ret_valid cycles, ret_last on the 4th; rd_rdy=1 the following cycle.
- Word write 0xbfaf8000, wstrb 0011, data 0x12345678 -> awlen 0, single beat wdata 0x12345678, wstrb 0011, wlast=1; wr_rdy=0 until the cycle after bvalid.
- Line write with wready low on alternate cycles -> words 0..3 emitted in order, wdata held while stalled, wlast only on word 3, strobe f.
- awready delayed until 3 cycles after the wlast handshake -> bready is not asserted before the AW handshake.
- Line write to 0x1c000080 pending, rd_req 0x1c000084 -> rd_rdy=0 until W_IDLE. rd_req 0x1c000100 is accepted immediately.
- resetn dropped during the 2nd R beat -> rready=0, arvalid=0, rd_rdy=1 asynchronously. A new read after release starts cleanly.
